// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for mem_bus_arbiter: FSM state encoding, one-hot grant
// constants and the default parameter values for bus widths and stall limit.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF      = 16;
   localparam int unsigned DATA_W_DEF      = 32;
   localparam int unsigned TIMEOUT_CYC_DEF = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_I = 2'd1,
      OWN_D = 2'd2
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_I    = 2'b01;
   localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Two-master arbiter sharing one memory slave between an instruction-fetch
// master (read-only) and a data master. Round-robin on simultaneous requests,
// no preemption, one idle cycle between grants.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN -- adds a slave stall counter that
// pulses the owner's err output and releases the bus after TIMEOUT_CYC
// stalled cycles. Without it, err outputs are tied low.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_cyc_i/i_stb_i/i_adr_i     fetch master request
//   i_dat_o/i_ack_o/i_err_o     fetch master response
//   d_cyc_i/d_stb_i/d_we_i      data master request control
//   d_adr_i/d_dat_i             data master address / write data
//   d_dat_o/d_ack_o/d_err_o     data master response
//   s_cyc_o..s_dat_o            shared slave request (muxed from owner)
//   s_dat_i/s_ack_i             slave response (routed to owner only)
//   grant_o                     registered one-hot owner (01 fetch, 10 data)
// -----------------------------------------------------------------------------
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cyc_i,
   input  logic              i_stb_i,
   input  logic [ADDR_W-1:0] i_adr_i,
   output logic [DATA_W-1:0] i_dat_o,
   output logic              i_ack_o,
   output logic              i_err_o,
   input  logic              d_cyc_i,
   input  logic              d_stb_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_adr_i,
   input  logic [DATA_W-1:0] d_dat_i,
   output logic [DATA_W-1:0] d_dat_o,
   output logic              d_ack_o,
   output logic              d_err_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [ADDR_W-1:0] s_adr_o,
   output logic [DATA_W-1:0] s_dat_o,
   input  logic [DATA_W-1:0] s_dat_i,
   input  logic              s_ack_i,
   output logic [1:0]        grant_o
);

   if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT_CYC must be in 1..65535");
   end

   arb_state_t state;
   logic [1:0] grant_q;
   logic       last_d;   // 1 when the data master received the most recent grant
   logic       timeout;

   assign grant_o = grant_q;

   // Request/response routing: only the current owner is connected; in IDLE
   // everything is zero, so a stray slave ack is dropped.
   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      i_dat_o = '0;
      i_ack_o = 1'b0;
      d_dat_o = '0;
      d_ack_o = 1'b0;
      unique case (state)
         OWN_I: begin
            s_cyc_o = i_cyc_i;
            s_stb_o = i_stb_i;
            s_adr_o = i_adr_i;
            i_dat_o = s_dat_i;
            i_ack_o = s_ack_i;
         end
         OWN_D: begin
            s_cyc_o = d_cyc_i;
            s_stb_o = d_stb_i;
            s_we_o  = d_we_i;
            s_adr_o = d_adr_i;
            s_dat_o = d_dat_i;
            d_dat_o = s_dat_i;
            d_ack_o = s_ack_i;
         end
         default: ;
      endcase
   end

   // Arbitration FSM. A tie in IDLE goes to the master not granted last.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant_q <= GNT_NONE;
         last_d  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_cyc_i && (!d_cyc_i || last_d)) begin
                  state   <= OWN_I;
                  grant_q <= GNT_I;
                  last_d  <= 1'b0;
               end else if (d_cyc_i) begin
                  state   <= OWN_D;
                  grant_q <= GNT_D;
                  last_d  <= 1'b1;
               end
            end
            OWN_I: begin
               if (!i_cyc_i || timeout) begin
                  state   <= IDLE;
                  grant_q <= GNT_NONE;
               end
            end
            OWN_D: begin
               if (!d_cyc_i || timeout) begin
                  state   <= IDLE;
                  grant_q <= GNT_NONE;
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= GNT_NONE;
            end
         endcase
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

   logic [15:0] stall_cnt;

   // Fires on the TIMEOUT_CYC-th consecutive stalled cycle; s_stb_o is only
   // high while an owner exists, so no separate state qualifier is needed.
   assign timeout = s_stb_o && !s_ack_i && (stall_cnt == TMO_LAST);
   assign i_err_o = timeout && (state == OWN_I);
   assign d_err_o = timeout && (state == OWN_D);

   // s_cyc_o low covers both IDLE and the owner dropping its cycle.
   always_ff @(posedge clk) begin
      if (rst || !s_cyc_o || s_ack_i || timeout) begin
         stall_cnt <= '0;
      end else if (s_stb_o) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`else
   assign timeout = 1'b0;
   assign i_err_o = 1'b0;
   assign d_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios followed by a randomized two-master run. Expected read
// data comes from a reference memory image; each issued beat pushes its
// expectation into a per-master queue and a monitor pops on every ack.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_cyc_i, i_stb_i;
   logic [AW-1:0] i_adr_i;
   logic [DW-1:0] i_dat_o;
   logic          i_ack_o, i_err_o;
   logic          d_cyc_i, d_stb_i, d_we_i;
   logic [AW-1:0] d_adr_i;
   logic [DW-1:0] d_dat_i;
   logic [DW-1:0] d_dat_o;
   logic          d_ack_o, d_err_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o;
   logic [DW-1:0] s_dat_i;
   logic          s_ack_i;
   logic [1:0]    grant_o;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_adr_i(i_adr_i),
      .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
      .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i),
      .d_adr_i(d_adr_i), .d_dat_i(d_dat_i),
      .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          wr;
      logic [DW-1:0] data;
   } exp_t;

   int            checks   = 0;
   int            failures = 0;
   exp_t          iq[$];
   exp_t          dq[$];
   logic [DW-1:0] ref_mem [512];
   logic [DW-1:0] slv_mem [512];
   bit            done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      i_cyc_i = 1'b0; i_stb_i = 1'b0; i_adr_i = '0;
      d_cyc_i = 1'b0; d_stb_i = 1'b0; d_we_i = 1'b0; d_adr_i = '0; d_dat_i = '0;
      s_ack_i = 1'b0; s_dat_i = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Waits for an ack on the selected master, bounded; an expired bound is a failure.
   task automatic wait_ack(input bit is_d);
      bit got;
      int w;
      got = 1'b0;
      w = 0;
      while (!got && w < 300) begin
         @(negedge clk);
         got = is_d ? d_ack_o : i_ack_o;
         w++;
      end
      if (!got) chk(is_d ? "d_ack_timeout" : "i_ack_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_master(input int bursts);
      for (int b = 0; b < bursts; b++) begin
         int gap;
         int beats;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick();
         beats = $urandom_range(1, 3);
         i_cyc_i = 1'b1;
         for (int k = 0; k < beats; k++) begin
            logic [8:0] a;
            exp_t e;
            a = 9'($urandom_range(0, 255));
            i_stb_i = 1'b1;
            i_adr_i = AW'(a);
            e.wr = 1'b0;
            e.data = ref_mem[a];
            iq.push_back(e);
            wait_ack(1'b0);
         end
         i_cyc_i = 1'b0;
         i_stb_i = 1'b0;
      end
   endtask

   task automatic data_master(input int bursts);
      for (int b = 0; b < bursts; b++) begin
         int gap;
         int beats;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick();
         beats = $urandom_range(1, 3);
         d_cyc_i = 1'b1;
         for (int k = 0; k < beats; k++) begin
            logic [8:0] a;
            exp_t e;
            a = 9'(256 + $urandom_range(0, 15));
            d_stb_i = 1'b1;
            d_adr_i = AW'(a);
            d_we_i = 1'($urandom_range(0, 1));
            if (d_we_i) begin
               d_dat_i = $urandom;
               ref_mem[a] = d_dat_i;
               e.wr = 1'b1;
               e.data = '0;
            end else begin
               d_dat_i = '0;
               e.wr = 1'b0;
               e.data = ref_mem[a];
            end
            dq.push_back(e);
            wait_ack(1'b1);
         end
         d_cyc_i = 1'b0;
         d_stb_i = 1'b0;
         d_we_i = 1'b0;
      end
   endtask

   // Memory slave with 0..2 cycles of latency; also throws stray acks while idle.
   task automatic slave_loop();
      int lat;
      logic [8:0] idx;
      lat = 0;
      while (!done) begin
         @(posedge clk);
         #2;
         s_ack_i = 1'b0;
         s_dat_i = '0;
         if (s_cyc_o && s_stb_o) begin
            if (lat == 0) begin
               s_ack_i = 1'b1;
               idx = s_adr_o[8:0];
               if (s_we_o) begin
                  slv_mem[idx] = s_dat_o;
                  s_dat_i = $urandom;
               end else begin
                  s_dat_i = slv_mem[idx];
               end
               lat = $urandom_range(0, 2);
            end else begin
               lat--;
            end
         end else if (grant_o == 2'b00 && $urandom_range(0, 5) == 0) begin
            s_ack_i = 1'b1;
            s_dat_i = $urandom;
         end
      end
      s_ack_i = 1'b0;
   endtask

   task automatic monitor_loop();
      logic [1:0] pg;
      exp_t e;
      bit legal;
      pg = 2'b00;
      while (!done) begin
         @(negedge clk);
         if (i_ack_o) begin
            if (iq.size() == 0) chk("i_ack_unexpected", 64'd1, 64'd0);
            else begin
               e = iq.pop_front();
               chk("i_rdata", 64'(i_dat_o), 64'(e.data));
            end
         end
         if (d_ack_o) begin
            if (dq.size() == 0) chk("d_ack_unexpected", 64'd1, 64'd0);
            else begin
               e = dq.pop_front();
               if (!e.wr) chk("d_rdata", 64'(d_dat_o), 64'(e.data));
            end
         end
         legal = (grant_o != 2'b11) && !(pg != 2'b00 && grant_o != 2'b00 && grant_o != pg);
         chk("grant_legal", 64'(legal), 64'd1);
         if (grant_o == 2'b01) begin
            chk("mux_i_adr", 64'(s_adr_o), 64'(i_adr_i));
            chk("mux_i_we", 64'(s_we_o), 64'd0);
         end else if (grant_o == 2'b10) begin
            chk("mux_d_adr", 64'(s_adr_o), 64'(d_adr_i));
            chk("mux_d_we", 64'(s_we_o), 64'(d_we_i));
         end else begin
            chk("idle_s_cyc", 64'(s_cyc_o), 64'd0);
         end
         chk("err_quiet", 64'({i_err_o, d_err_o}), 64'd0);
         pg = grant_o;
      end
   endtask

   initial begin
      int n_stall;
      for (int i = 0; i < 512; i++) begin
         ref_mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
         slv_mem[i] = ref_mem[i];
      end

      // Reset state
      rst = 1'b1;
      clear_inputs();
      tick();
      smp();
      chk("rst_grant", 64'(grant_o), 64'd0);
      chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
      chk("rst_acks", 64'({i_ack_o, d_ack_o}), 64'd0);
      tick();
      rst = 1'b0;

      // Fetch-only read
      i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 16'h0010;
      smp();
      chk("f_pre_grant", 64'(grant_o), 64'd0);
      tick();
      smp();
      chk("f_grant", 64'(grant_o), 64'b01);
      chk("f_s_adr", 64'(s_adr_o), 64'h0010);
      chk("f_s_we", 64'(s_we_o), 64'd0);
      tick();
      s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
      smp();
      chk("f_i_ack", 64'(i_ack_o), 64'd1);
      chk("f_i_dat", 64'(i_dat_o), 64'hDEAD_BEEF);
      chk("f_d_ack", 64'(d_ack_o), 64'd0);
      chk("f_d_dat", 64'(d_dat_o), 64'd0);
      tick();
      clear_inputs();
      tick();
      smp();
      chk("f_release", 64'(grant_o), 64'd0);

      // Tie after reset: data first, one idle cycle, then fetch
      do_reset();
      i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 16'h0020;
      d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 16'h0104;
      tick();
      smp();
      chk("rr_first_d", 64'(grant_o), 64'b10);
      tick();
      d_cyc_i = 1'b0; d_stb_i = 1'b0;
      tick();
      smp();
      chk("rr_idle_gap", 64'(grant_o), 64'd0);
      tick();
      smp();
      chk("rr_then_i", 64'(grant_o), 64'b01);
      tick();
      i_cyc_i = 1'b0; i_stb_i = 1'b0;
      tick();

      // Data write, 3 beats, fetch pending and ignored
      d_cyc_i = 1'b1; d_stb_i = 1'b1; d_we_i = 1'b1;
      d_adr_i = 16'h0100; d_dat_i = 32'h1234_5678;
      i_cyc_i = 1'b1; i_stb_i = 1'b1;
      tick();
      s_ack_i = 1'b1; s_dat_i = 32'h0BAD_0BAD;
      for (int b = 0; b < 3; b++) begin
         smp();
         chk("w_grant", 64'(grant_o), 64'b10);
         chk("w_s_we", 64'(s_we_o), 64'd1);
         chk("w_s_adr", 64'(s_adr_o), 64'h0100);
         chk("w_s_dat", 64'(s_dat_o), 64'h1234_5678);
         chk("w_d_ack", 64'(d_ack_o), 64'd1);
         chk("w_i_ack", 64'(i_ack_o), 64'd0);
         tick();
      end
      s_ack_i = 1'b0; s_dat_i = '0;
      d_cyc_i = 1'b0; d_stb_i = 1'b0; d_we_i = 1'b0;
      smp();
      chk("w_hold_last", 64'(grant_o), 64'b10);
      tick();
      smp();
      chk("w_idle", 64'(grant_o), 64'd0);
      tick();
      smp();
      chk("w_fetch_next", 64'(grant_o), 64'b01);
      tick();
      i_cyc_i = 1'b0; i_stb_i = 1'b0;
      tick();

      // Reset mid-stall in OWN_D, with an ack landing in the reset cycle
      d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 16'h0104;
      tick();
      smp();
      chk("r_grant_d", 64'(grant_o), 64'b10);
      tick();
      rst = 1'b1; s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
      tick();
      rst = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
      smp();
      chk("r_grant", 64'(grant_o), 64'd0);
      chk("r_s_cyc", 64'(s_cyc_o), 64'd0);
      chk("r_acks", 64'({i_ack_o, d_ack_o}), 64'd0);
      chk("r_d_dat", 64'(d_dat_o), 64'd0);
      tick();
      s_ack_i = 1'b0; s_dat_i = '0;

      // Stalled slave
      d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 16'h0108;
      tick();
`ifdef MEM_ARB_TIMEOUT_EN
      n_stall = 5;
`else
      n_stall = 12;
`endif
      for (int k = 1; k <= n_stall; k++) begin
         smp();
`ifdef MEM_ARB_TIMEOUT_EN
         chk("t_d_err", 64'(d_err_o), (k == 4) ? 64'd1 : 64'd0);
         chk("t_grant", 64'(grant_o), (k <= 4) ? 64'b10 : 64'd0);
`else
         chk("t_d_err", 64'(d_err_o), 64'd0);
         chk("t_grant", 64'(grant_o), 64'b10);
`endif
         chk("t_i_err", 64'(i_err_o), 64'd0);
         tick();
      end
      d_cyc_i = 1'b0; d_stb_i = 1'b0;
      tick();
      tick();

      // Randomized contention
      do_reset();
      fork
         begin
            fork
               fetch_master(40);
               data_master(40);
            join
            repeat (4) @(posedge clk);
            done = 1'b1;
         end
         slave_loop();
         monitor_loop();
      join
      chk("iq_drained", 64'(iq.size()), 64'd0);
      chk("dq_drained", 64'(dq.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
